apb_master_bridge: RTL and testbench
====================================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum ACCESS-phase cycles before abort; legal range 1..65535.
REQ-003 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have ports req_valid / req_ready, input / output, 1 each, request handshake.
REQ-006 SHALL have ports req_addr, req_write, req_wdata, req_wstrb, req_prot: inputs of widths ADDR_W, 1, 32, 4, 3; the request payload.
REQ-007 SHALL have ports resp_valid / resp_ready, output / input, 1 each, response handshake.
REQ-008 SHALL have ports resp_rdata, resp_err, resp_timeout: outputs of widths 32, 1, 1; the response payload.
REQ-009 SHALL have ports out_psel, out_penable, out_pwrite, out_paddr, out_pwdata, out_pstrb, out_pprot: outputs of widths 1, 1, 1, ADDR_W, 32, 4, 3; APB requester side.
REQ-010 SHALL have ports out_pready, out_prdata, out_pslverr: inputs of widths 1, 32, 1; APB completer returns.

Function
REQ-011 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-012 IDLE: req_ready=1; on req_valid&req_ready, payload SHALL be registered and the FSM SHALL go to SETUP.
REQ-013 SETUP (exactly 1 cycle): out_psel=1, out_penable=0; next state ACCESS.
REQ-014 ACCESS: out_psel=1, out_penable=1; on out_pready=1, out_prdata and out_pslverr SHALL be captured and the FSM SHALL go to RESP.
REQ-015 out_paddr, out_pwrite, out_pwdata, out_pstrb and out_pprot SHALL be registered and stable from SETUP through the final ACCESS cycle.
REQ-016 out_pwdata and out_pstrb SHALL be driven 0 on reads; out_pstrb SHALL be req_wstrb on writes.
REQ-017 A 16-bit watchdog SHALL clear on entering ACCESS and increment on each ACCESS cycle with out_pready=0.
REQ-018 When the watchdog reaches TIMEOUT_CYCLES, the FSM SHALL go to RESP with resp_err=1, resp_timeout=1, resp_rdata=0, and SHALL drop out_psel the next cycle.
REQ-019 out_pready=1 in the same cycle as the watchdog limit SHALL win: normal completion, no timeout.
REQ-020 RESP: resp_valid=1 with payload held stable until resp_ready=1, then IDLE; resp_ready=0 stalls indefinitely with no new request accepted.
REQ-021 resp_rdata SHALL be captured out_prdata on reads and 0 on writes; resp_err SHALL equal out_pslverr on normal completion.
REQ-022 out_pready, out_prdata and out_pslverr SHALL be ignored outside ACCESS.
REQ-023 Minimum latency SHALL be: accept at cycle 0, SETUP cycle 1, ACCESS cycle 2, resp_valid cycle 3; back-to-back requests SHALL have at least one IDLE cycle between transfers.
REQ-024 All outputs SHALL be register-driven, except req_ready, which SHALL decode the state register.

Reset
REQ-025 On reset=1 the FSM SHALL go to IDLE from any state, including mid-ACCESS, abandoning the transfer with no response.
REQ-026 Reset values SHALL be: req_ready=0 during reset and 1 after; out_psel, out_penable, out_pwrite, resp_valid, resp_err and resp_timeout 0; out_paddr, out_pwdata, out_pstrb, out_pprot, resp_rdata and watchdog 0.

Structure
REQ-027 Package apb_master_pkg SHALL hold the FSM state enum (2-bit), the APB data width (32) and strobe width (4) constants.
REQ-028 The watchdog SHALL be a sub-module apb_timeout_cnt with ports clear, enable, limit and expired; all else stays in apb_master_bridge.

Verification
REQ-029 Write: addr 0x1000_0004, wdata 0x0000_00A5, wstrb 0x1, pready=1 on first ACCESS -> psel high 2 cycles, penable 1 cycle, resp_valid at cycle 3, resp_err=0, resp_rdata=0.
REQ-030 Read: addr 0x1000_0000, completer 3 wait states then prdata 0x5A5A_5A5A -> ACCESS lasts 4 cycles, paddr stable, resp_rdata=0x5A5A_5A5A, resp_err=0.
REQ-031 Error: pslverr=1 with pready=1 on a read -> resp_err=1, resp_timeout=0.
REQ-032 Timeout: TIMEOUT_CYCLES=4, pready held 0 -> after 4 ACCESS cycles resp_err=1, resp_timeout=1, psel low the next cycle; repeat with pready=1 on the 4th cycle -> no timeout.
REQ-033 Backpressure: resp_ready=0 for 10 cycles with req_valid=1 -> resp payload stable, req_ready=0, no new SETUP; resp_ready=1 -> IDLE, next request accepted.
REQ-034 Reset mid-ACCESS: assert reset during the 2nd wait state -> next cycle psel=0, penable=0, resp_valid=0, FSM in IDLE.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types and widths for the APB requester bridge and its watchdog.
package apb_master_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_resp_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog: 16-bit count of stalled cycles; expired flags, combinationally,
// the cycle whose increment reaches limit. No backpressure; clear wins over enable.
module apb_timeout_cnt (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 16'd0;
    end else if (enable) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && !clear && ((cnt_q + 16'd1) == limit);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready request to APB requester bridge: accept->SETUP->ACCESS->RESP, 3 cycles min to resp_valid.
// One transfer in flight; resp_ready low holds the response and blocks new requests.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic                  req_write,
  input  logic [APB_DATA_W-1:0] req_wdata,
  input  logic [APB_STRB_W-1:0] req_wstrb,
  input  logic [2:0]            req_prot,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [APB_DATA_W-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  resp_timeout,
  output logic                  out_psel,
  output logic                  out_penable,
  output logic                  out_pwrite,
  output logic [ADDR_W-1:0]     out_paddr,
  output logic [APB_DATA_W-1:0] out_pwdata,
  output logic [APB_STRB_W-1:0] out_pstrb,
  output logic [2:0]            out_pprot,
  input  logic                  out_pready,
  input  logic [APB_DATA_W-1:0] out_prdata,
  input  logic                  out_pslverr
);

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  apb_state_e            state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  logic [APB_STRB_W-1:0] pstrb_q, pstrb_d;
  logic [2:0]            pprot_q, pprot_d;
  logic                  resp_valid_q, resp_valid_d;
  apb_resp_t             resp_q, resp_d;
  logic                  wd_expired;

  apb_timeout_cnt u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_q == ST_SETUP),
    .enable  ((state_q == ST_ACCESS) && !out_pready),
    .limit   (TIMEOUT_LIM),
    .expired (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pprot_d  = pprot_q;
    resp_d   = resp_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d  = ST_SETUP;
          pwrite_d = req_write;
          paddr_d  = req_addr;
          pwdata_d = req_write ? req_wdata : '0;
          pstrb_d  = req_write ? req_wstrb : '0;
          pprot_d  = req_prot;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A completer answer in the watchdog's final cycle still counts as a normal completion.
        if (out_pready) begin
          state_d        = ST_RESP;
          resp_d.rdata   = pwrite_q ? '0 : out_prdata;
          resp_d.err     = out_pslverr;
          resp_d.timeout = 1'b0;
        end else if (wd_expired) begin
          state_d        = ST_RESP;
          resp_d.rdata   = '0;
          resp_d.err     = 1'b1;
          resp_d.timeout = 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    psel_d       = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d    = (state_d == ST_ACCESS);
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      pprot_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      pprot_q      <= pprot_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE) && !reset;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_q.rdata;
  assign resp_err     = resp_q.err;
  assign resp_timeout = resp_q.timeout;
  assign out_psel     = psel_q;
  assign out_penable  = penable_q;
  assign out_pwrite   = pwrite_q;
  assign out_paddr    = paddr_q;
  assign out_pwdata   = pwdata_q;
  assign out_pstrb    = pstrb_q;
  assign out_pprot    = pprot_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed scoreboard bench for apb_master_bridge with a short watchdog limit.
module tb_apb_master_bridge;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic [2:0]  req_prot = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_timeout;
  logic        out_psel;
  logic        out_penable;
  logic        out_pwrite;
  logic [31:0] out_paddr;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic [2:0]  out_pprot;
  logic        out_pready = 1'b0;
  logic [31:0] out_prdata = '0;
  logic        out_pslverr = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  apb_master_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clock        (clk),
    .reset        (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_write    (req_write),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .req_prot     (req_prot),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .resp_timeout (resp_timeout),
    .out_psel     (out_psel),
    .out_penable  (out_penable),
    .out_pwrite   (out_pwrite),
    .out_paddr    (out_paddr),
    .out_pwdata   (out_pwdata),
    .out_pstrb    (out_pstrb),
    .out_pprot    (out_pprot),
    .out_pready   (out_pready),
    .out_prdata   (out_prdata),
    .out_pslverr  (out_pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Runs one transfer starting at an IDLE negedge and ends at the following IDLE negedge.
  task automatic xfer(input string name, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wd, input logic [3:0] ws, input logic [2:0] pr,
                      input int waits, input logic [31:0] rd, input logic serr,
                      input logic exp_tmo, input int n_acc_exp, input int stall);
    exp_t e;
    exp_t got;
    int   n_acc;
    logic stable;
    chk({name, "_req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_addr = addr; req_write = wr;
    req_wdata = wd; req_wstrb = ws; req_prot = pr;
    e.rdata = (wr || exp_tmo) ? 32'h0 : rd;
    e.err   = exp_tmo ? 1'b1 : serr;
    e.tmo   = exp_tmo;
    sb_q.push_back(e);
    cyc();
    req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
    chk({name, "_setup_psel"}, out_psel, 1);
    chk({name, "_setup_penable"}, out_penable, 0);
    chk({name, "_paddr"}, out_paddr, addr);
    chk({name, "_pwrite"}, out_pwrite, wr);
    chk({name, "_pwdata"}, out_pwdata, wr ? wd : 32'h0);
    chk({name, "_pstrb"}, out_pstrb, wr ? ws : 4'h0);
    chk({name, "_pprot"}, out_pprot, pr);
    // Completer noise during SETUP must be ignored.
    out_pready = 1'b1; out_pslverr = 1'b1; out_prdata = 32'hDEAD_BEEF;
    n_acc  = 0;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (!(out_psel && out_penable)) break;
      n_acc++;
      if (out_paddr !== addr || out_pwrite !== wr || out_pprot !== pr) stable = 1'b0;
      out_pready  = (i == waits);
      out_prdata  = rd;
      out_pslverr = serr;
    end
    out_pready = 1'b0; out_pslverr = 1'b1; out_prdata = 32'hFFFF_FFFF;
    chk({name, "_access_cycles"}, n_acc, n_acc_exp);
    chk({name, "_addr_stable"}, stable, 1);
    chk({name, "_resp_valid"}, resp_valid, 1);
    chk({name, "_resp_psel"}, out_psel, 0);
    chk({name, "_resp_penable"}, out_penable, 0);
    chk({name, "_sb_nonempty"}, (sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      chk({name, "_rdata"}, resp_rdata, got.rdata);
      chk({name, "_err"}, resp_err, got.err);
      chk({name, "_timeout"}, resp_timeout, got.tmo);
    end
    if (stall > 0) begin
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      stable     = 1'b1;
      for (int k = 0; k < stall; k++) begin
        cyc();
        if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err ||
            resp_timeout !== e.tmo || req_ready !== 1'b0 || out_psel !== 1'b0) stable = 1'b0;
      end
      chk({name, "_stall_hold"}, stable, 1);
      resp_ready = 1'b1;
    end
    cyc();
    req_valid = 1'b0;
    chk({name, "_idle_resp_valid"}, resp_valid, 0);
    chk({name, "_idle_req_ready"}, req_ready, 1);
  endtask

  initial begin
    cyc();
    chk("rst_req_ready", req_ready, 0);
    cyc();
    chk("rst_psel", out_psel, 0);
    chk("rst_penable", out_penable, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_paddr", out_paddr, 0);
    chk("rst_pwdata", out_pwdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_timeout", resp_timeout, 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_req_ready", req_ready, 1);

    xfer("wr", 32'h1000_0004, 1'b1, 32'h0000_00A5, 4'h1, 3'd2, 0, 32'h0, 1'b0, 1'b0, 1, 0);
    xfer("rd3w", 32'h1000_0000, 1'b0, 32'h1111_2222, 4'hF, 3'd0, 3, 32'h5A5A_5A5A, 1'b0, 1'b0, 4, 0);
    xfer("slverr", 32'h1000_0008, 1'b0, 32'h0, 4'h0, 3'd1, 0, 32'hCAFE_F00D, 1'b1, 1'b0, 1, 0);
    xfer("tmo", 32'h1000_000C, 1'b0, 32'h0, 4'h0, 3'd0, 99, 32'h1234_5678, 1'b0, 1'b1, TMO, 0);
    xfer("edge", 32'h1000_0010, 1'b0, 32'h0, 4'h0, 3'd0, TMO - 1, 32'h0BAD_CAFE, 1'b0, 1'b0, TMO, 0);
    xfer("bp", 32'h2000_0040, 1'b1, 32'hA5A5_0F0F, 4'hC, 3'd3, 1, 32'h0, 1'b0, 1'b0, 2, 10);
    xfer("after_bp", 32'h2000_0044, 1'b0, 32'h0, 4'h0, 3'd0, 0, 32'h7777_0001, 1'b0, 1'b0, 1, 0);

    // Reset in the second ACCESS wait state abandons the transfer silently.
    chk("mid_rst_req_ready", req_ready, 1);
    req_valid = 1'b1; req_addr = 32'h3000_0000; req_write = 1'b0;
    cyc();
    req_valid = 1'b0;
    out_pready = 1'b0;
    chk("mid_rst_setup", out_psel, 1);
    cyc();
    chk("mid_rst_wait1", out_penable, 1);
    cyc();
    chk("mid_rst_wait2", out_penable, 1);
    rst = 1'b1;
    cyc();
    chk("mid_rst_psel", out_psel, 0);
    chk("mid_rst_penable", out_penable, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    rst = 1'b0;
    cyc();
    chk("mid_rst_idle", req_ready, 1);
    chk("mid_rst_resp_valid2", resp_valid, 0);

    xfer("recover", 32'h3000_0004, 1'b1, 32'hFEED_0001, 4'h3, 3'd0, 0, 32'h0, 1'b0, 1'b0, 1, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
